// File: rtl/column_window_reader_pkg.sv
// Shared row-buffer definitions: reader FSM encoding and width helpers
// used by both the column reader and the write-address logic.
package column_window_reader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        HOLD,
        DONE
    } rb_state_e;

    // Never return a zero width, so degenerate parameters still give legal vectors
    function automatic int rb_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int rb_addr_w(input int mem_depth);
        return rb_width(mem_depth);
    endfunction

endpackage

// File: rtl/column_window_reader_rb_slot_addr.sv
// Row-buffer slot address: slot rows are interleaved, so pixel (row, col)
// lives at row + col*RB_COUNT, with the row index wrapped before scaling.
module rb_slot_addr
    import column_window_reader_pkg::*;
#(
    parameter int RB_COUNT    = 8,
    parameter int IMAGE_WIDTH = 256,
    parameter int WIN_ROWS    = 3,
    parameter int MEM_DEPTH   = RB_COUNT * IMAGE_WIDTH
) (
    input  logic [rb_width(RB_COUNT)-1:0]    top_row,
    input  logic [rb_width(WIN_ROWS)-1:0]    k,
    input  logic [rb_width(IMAGE_WIDTH)-1:0] col,
    output logic [rb_addr_w(MEM_DEPTH)-1:0]  addr
);

    localparam int TW = rb_width(RB_COUNT);
    localparam int AW = rb_addr_w(MEM_DEPTH);
    localparam int SW = TW + 1;

    logic [SW-1:0] row_sum;
    logic [TW-1:0] row;

    // top_row < RB_COUNT and k < WIN_ROWS <= RB_COUNT, so one conditional subtract is a full modulo
    always_comb begin
        row_sum = {1'b0, top_row} + SW'(k);
        if (row_sum >= SW'(RB_COUNT)) begin
            row_sum = row_sum - SW'(RB_COUNT);
        end
        row  = row_sum[TW-1:0];
        addr = AW'(row) + AW'(col) * AW'(RB_COUNT);
    end

endmodule

// File: rtl/column_window_reader.sv
// Column window reader: walks one image line column by column, reading
// WIN_ROWS resident rows from the interleaved row-buffer BRAM per column.
module column_window_reader
    import column_window_reader_pkg::*;
#(
    parameter int RB_COUNT    = 8,
    parameter int IMAGE_WIDTH = 256,
    parameter int WIN_ROWS    = 3,
    parameter int PIXEL_W     = 8,
    parameter int MEM_DEPTH   = RB_COUNT * IMAGE_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            line_go,
    output logic                            rd_en,
    output logic [rb_addr_w(MEM_DEPTH)-1:0] rd_addr,
    input  logic [PIXEL_W-1:0]              rd_data,
    output logic [WIN_ROWS*PIXEL_W-1:0]     col_data,
    output logic                            col_valid,
    input  logic                            col_ready,
    output logic [rb_width(RB_COUNT)-1:0]   top_row,
    output logic                            row_release,
    output logic                            busy
);

    localparam int TW = rb_width(RB_COUNT);
    localparam int KW = rb_width(WIN_ROWS);
    localparam int CW = rb_width(IMAGE_WIDTH);
    localparam int AW = rb_addr_w(MEM_DEPTH);

    localparam logic [KW-1:0] K_LAST = KW'(WIN_ROWS - 1);
    localparam logic [CW-1:0] C_LAST = CW'(IMAGE_WIDTH - 1);
    localparam logic [TW-1:0] T_LAST = TW'(RB_COUNT - 1);

    rb_state_e state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [CW-1:0] col_q, col_d;
    logic [TW-1:0] top_q, top_d;
    logic          pend_q, pend_d;

    logic                        rdv_q;
    logic [KW-1:0]               capk_q;
    logic [WIN_ROWS*PIXEL_W-1:0] col_data_q;
    logic [AW-1:0]               slot_addr;

    rb_slot_addr #(
        .RB_COUNT    (RB_COUNT),
        .IMAGE_WIDTH (IMAGE_WIDTH),
        .WIN_ROWS    (WIN_ROWS),
        .MEM_DEPTH   (MEM_DEPTH)
    ) u_slot_addr (
        .top_row (top_q),
        .k       (k_q),
        .col     (col_q),
        .addr    (slot_addr)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            col_q   <= '0;
            top_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            col_q   <= col_d;
            top_q   <= top_d;
            pend_q  <= pend_d;
        end
    end

    // A go that lands while a line is in flight (including the DONE cycle) is remembered once
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        col_d   = col_q;
        top_d   = top_q;
        pend_d  = pend_q;
        if (line_go && (state_q != IDLE)) begin
            pend_d = 1'b1;
        end
        case (state_q)
            IDLE: begin
                col_d = '0;
                k_d   = '0;
                if (line_go || pend_q) begin
                    state_d = ISSUE;
                    pend_d  = 1'b0;
                end
            end
            ISSUE: begin
                if (k_q == K_LAST) begin
                    state_d = DRAIN;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            DRAIN: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (col_ready) begin
                    k_d = '0;
                    if (col_q == C_LAST) begin
                        state_d = DONE;
                    end else begin
                        col_d   = col_q + CW'(1);
                        state_d = ISSUE;
                    end
                end
            end
            DONE: begin
                top_d   = (top_q == T_LAST) ? '0 : top_q + TW'(1);
                col_d   = '0;
                k_d     = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Read data returns one cycle after issue; capk_q tracks which window row it belongs to
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdv_q      <= 1'b0;
            capk_q     <= '0;
            col_data_q <= '0;
        end else begin
            rdv_q  <= rd_en;
            capk_q <= k_q;
            for (int r = 0; r < WIN_ROWS; r++) begin
                if (rdv_q && (capk_q == KW'(r))) begin
                    col_data_q[r*PIXEL_W +: PIXEL_W] <= rd_data;
                end
            end
        end
    end

    assign rd_en       = (state_q == ISSUE);
    assign rd_addr     = rd_en ? slot_addr : '0;
    assign col_data    = col_data_q;
    assign col_valid   = (state_q == HOLD);
    assign top_row     = top_q;
    assign row_release = (state_q == DONE);
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_column_window_reader.sv
// Scoreboard bench for column_window_reader: expected addresses and columns
// are queued per line from a slot/column model and popped by monitors.
module tb_column_window_reader;

    localparam int RB = 8;
    localparam int IW = 256;
    localparam int WR = 3;
    localparam int PW = 8;
    localparam int MD = RB * IW;
    localparam int AW = 11;
    localparam int TW = 3;
    localparam int BOUND = 20000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic lineGo = 1'b0;
    logic colReady = 1'b0;
    logic rdEn, colValid, rowRelease, busy;
    logic [AW-1:0] rdAddr;
    logic [PW-1:0] rdData = '0;
    logic [WR*PW-1:0] colData;
    logic [TW-1:0] topRow;

    int tests = 0;
    int fails = 0;
    int colsSeen = 0;
    int releaseCount = 0;
    int readyMode = 2;
    int modelTop = 0;

    logic [AW-1:0] expAddr[$];
    logic [WR*PW-1:0] expCol[$];

    always #5 clk = ~clk;

    column_window_reader #(
        .RB_COUNT    (RB),
        .IMAGE_WIDTH (IW),
        .WIN_ROWS    (WR),
        .PIXEL_W     (PW),
        .MEM_DEPTH   (MD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .line_go     (lineGo),
        .rd_en       (rdEn),
        .rd_addr     (rdAddr),
        .rd_data     (rdData),
        .col_data    (colData),
        .col_valid   (colValid),
        .col_ready   (colReady),
        .top_row     (topRow),
        .row_release (rowRelease),
        .busy        (busy)
    );

    // BRAM model: each location holds the low byte of its own address
    always @(posedge clk) begin
        if (rdEn) rdData <= rdAddr[7:0];
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic reportTimeout(input string name);
        tests++;
        fails++;
        $display("[TB] FAIL %s: timed out after %0d cycles, expected event", name, BOUND);
    endtask

    function automatic logic [AW-1:0] slotAddr(input int t, input int k, input int c);
        return AW'(((t + k) % RB) + c * RB);
    endfunction

    function automatic logic [WR*PW-1:0] colValue(input int t, input int c);
        logic [WR*PW-1:0] v;
        logic [AW-1:0] a;
        v = '0;
        for (int k = 0; k < WR; k++) begin
            a = slotAddr(t, k, c);
            v[k*PW +: PW] = a[7:0];
        end
        return v;
    endfunction

    // Queue the whole line's expected reads and columns, then advance the model's top row
    task automatic pushLine();
        for (int c = 0; c < IW; c++) begin
            for (int k = 0; k < WR; k++) expAddr.push_back(slotAddr(modelTop, k, c));
            expCol.push_back(colValue(modelTop, c));
        end
        modelTop = (modelTop + 1) % RB;
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        #1 lineGo = 1'b1;
        @(posedge clk);
        #1 lineGo = 1'b0;
    endtask

    task automatic startLine();
        pushLine();
        applyStimulus();
    endtask

    task automatic waitIdle(input string name);
        int quiet;
        quiet = 0;
        for (int i = 0; i < BOUND && quiet < 3; i++) begin
            @(negedge clk);
            quiet = busy ? 0 : quiet + 1;
        end
        if (quiet < 3) reportTimeout(name);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_rd_en"}, rdEn, 0);
        checkOutput({tag, "_rd_addr"}, rdAddr, 0);
        checkOutput({tag, "_col_data"}, colData, 0);
        checkOutput({tag, "_col_valid"}, colValid, 0);
        checkOutput({tag, "_row_release"}, rowRelease, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_top_row"}, topRow, 0);
    endtask

    // Ready driver: 0 = always ready, 1 = random throttle, 2 = driven by the main sequence
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (readyMode == 0) colReady = 1'b1;
            else if (readyMode == 1) colReady = 1'($urandom_range(0, 1));
        end
    end

    always @(negedge clk) begin
        if (rst && rdEn) begin
            if (expAddr.size() == 0) begin
                reportTimeout("rd_addr_unexpected_read");
            end else begin
                checkOutput("rd_addr", rdAddr, expAddr.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst && colValid && colReady) begin
            if (expCol.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL col_data_unexpected: got 0x%0h, expected no column", colData);
            end else begin
                checkOutput("col_data", colData, expCol.pop_front());
            end
            colsSeen++;
        end
    end

    always @(negedge clk) begin
        if (rowRelease) releaseCount++;
    end

    initial begin
        int base;
        int n;
        bit seen;

        repeat (2) @(negedge clk);
        checkResetOutputs("reset");
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (5) begin
            @(negedge clk);
            checkOutput("idle_no_read", rdEn, 0);
        end

        // Line 1: first-column latency, then a 10-cycle stall on column 3
        readyMode = 2;
        colReady = 1'b1;
        startLine();
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            checkOutput("col_valid_latency", colValid, (i == 4));
            if (i == 4) checkOutput("first_col_data", colData, 24'h020100);
        end
        n = 0;
        while (colsSeen < 3 && n < BOUND) begin @(negedge clk); n++; end
        if (colsSeen < 3) reportTimeout("reach_col2");
        @(posedge clk);
        #1 colReady = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!colValid && n < BOUND);
        if (!colValid) reportTimeout("col3_valid");
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            checkOutput("hold_col_data", colData, colValue(0, 3));
            checkOutput("hold_col_valid", colValid, 1);
            checkOutput("hold_rd_en", rdEn, 0);
        end
        @(posedge clk);
        #1 colReady = 1'b1;
        readyMode = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!rdEn && n < BOUND);
        checkOutput("resume_addr", rdAddr, 32);
        waitIdle("line1_idle");
        checkOutput("top_row_line1", topRow, modelTop);

        // Lines 2..8: top row walks to 7 then wraps; the last four are randomly throttled
        for (int ln = 2; ln <= 8; ln++) begin
            readyMode = (ln >= 5) ? 1 : 0;
            startLine();
            waitIdle("line_idle");
            checkOutput("top_row_advance", topRow, modelTop);
        end
        checkOutput("top_row_wrap", topRow, 0);

        // Three extra go pulses while busy collapse into exactly one more line
        readyMode = 0;
        base = releaseCount;
        startLine();
        repeat (20) @(posedge clk);
        for (int p = 0; p < 3; p++) begin
            applyStimulus();
            repeat (5) @(posedge clk);
        end
        pushLine();
        waitIdle("pending_idle");
        checkOutput("release_count", releaseCount - base, 2);
        checkOutput("top_row_pending", topRow, modelTop);
        checkOutput("col_queue_empty_pending", expCol.size(), 0);

        // A go in the DONE cycle is kept pending and restarts after a single IDLE cycle
        startLine();
        seen = 1'b0;
        for (int i = 0; i < BOUND && !seen; i++) begin
            @(negedge clk);
            seen = rowRelease;
        end
        if (!seen) reportTimeout("done_release");
        lineGo = 1'b1;
        pushLine();
        @(posedge clk);
        #1 lineGo = 1'b0;
        checkOutput("done_go_idle_busy", busy, 0);
        checkOutput("done_go_idle_release", rowRelease, 0);
        @(posedge clk);
        #1;
        checkOutput("done_go_restart_busy", busy, 1);
        checkOutput("done_go_restart_rd_en", rdEn, 1);
        waitIdle("done_go_idle");
        checkOutput("top_row_done_go", topRow, modelTop);

        // Reset at column 100 abandons the line; the next line starts over at slot 0
        startLine();
        base = colsSeen;
        n = 0;
        while ((colsSeen - base) < 100 && n < BOUND) begin @(negedge clk); n++; end
        if ((colsSeen - base) < 100) reportTimeout("reach_col100");
        @(posedge clk);
        #2 rst = 1'b0;
        #1 checkResetOutputs("midline_reset");
        expAddr.delete();
        expCol.delete();
        modelTop = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (5) begin
            @(negedge clk);
            checkOutput("post_reset_no_read", rdEn, 0);
        end
        readyMode = 1;
        startLine();
        @(negedge clk);
        checkOutput("restart_rd_en", rdEn, 1);
        checkOutput("restart_addr", rdAddr, 0);
        waitIdle("restart_idle");
        checkOutput("top_row_restart", topRow, modelTop);

        checkOutput("addr_queue_empty", expAddr.size(), 0);
        checkOutput("col_queue_empty", expCol.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/column_window_reader.md
COLUMN_WINDOW_READER -- requirements
Module: column_window_reader

Interface
REQ-001 SHALL have parameter RB_COUNT, default 8: number of row-buffer slots interleaved in the BRAM.
REQ-002 SHALL have parameter IMAGE_WIDTH, default 256: pixels per row.
REQ-003 SHALL have parameter WIN_ROWS, default 3: rows per output column; legal range 1..RB_COUNT.
REQ-004 SHALL have parameter PIXEL_W, default 8: pixel width in bits.
REQ-005 SHALL have parameter MEM_DEPTH, default RB_COUNT*IMAGE_WIDTH: BRAM depth.
REQ-006 SHALL have port clk, input, 1 bit: the only clock; all state on the rising edge.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port line_go, input, 1 bit: one-cycle pulse meaning the next WIN_ROWS rows are resident (driven from the writer's frame_filled or the line controller).
REQ-009 SHALL have port rd_en, output, 1 bit: BRAM read enable.
REQ-010 SHALL have port rd_addr, output, $clog2(MEM_DEPTH) bits: BRAM read address.
REQ-011 SHALL have port rd_data, input, PIXEL_W bits: BRAM read data, valid exactly 1 cycle after rd_en.
REQ-012 SHALL have port col_data, output, WIN_ROWS*PIXEL_W bits: window column; row k (oldest = 0) in bits [k*PIXEL_W +: PIXEL_W].
REQ-013 SHALL have port col_valid, output, 1 bit: col_data is valid.
REQ-014 SHALL have port col_ready, input, 1 bit: consumer accepts col_data.
REQ-015 SHALL have port top_row, output, $clog2(RB_COUNT) bits: slot index of the oldest window row.
REQ-016 SHALL have port row_release, output, 1 bit: one-cycle pulse; slot top_row (pre-advance value) may be overwritten.
REQ-017 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-018 SHALL implement the FSM IDLE->ISSUE->DRAIN->HOLD->(ISSUE | DONE)->IDLE.
REQ-019 In IDLE, SHALL leave IDLE on line_go or a set pending flag; col = 0, k = 0.
REQ-020 In ISSUE, SHALL assert rd_en for WIN_ROWS consecutive cycles, with rd_addr = ((top_row+k) mod RB_COUNT) + col*RB_COUNT for k = 0..WIN_ROWS-1.
REQ-021 SHALL enter DRAIN after the last issue and capture returning rd_data into slot k of col_data, in issue order.
REQ-022 SHALL assert col_valid in the cycle after the last datum is captured, i.e. WIN_ROWS+2 cycles after leaving IDLE.
REQ-023 SHALL enter HOLD while col_valid is high and keep col_data stable until col_valid&&col_ready; it SHALL issue no reads while holding.
REQ-024 On acceptance with col < IMAGE_WIDTH-1, SHALL increment col, deassert col_valid and return to ISSUE on the next cycle.
REQ-025 On acceptance with col == IMAGE_WIDTH-1, SHALL enter DONE.
REQ-026 In DONE, SHALL pulse row_release for 1 cycle, advance top_row by 1 mod RB_COUNT (wrap RB_COUNT-1 -> 0), then return to IDLE.
REQ-027 SHALL set a single-bit pending flag when line_go arrives while busy; extra pulses SHALL be dropped (no count beyond 1); pending SHALL be cleared on leaving IDLE.
REQ-028 A line_go arriving in the same cycle as the DONE->IDLE transition SHALL set pending, and IDLE SHALL exit on the next cycle.
REQ-029 SHALL compute addresses with the modulo performed on the row index before scaling; rd_addr SHALL never exceed MEM_DEPTH-1.
REQ-030 SHALL drive rd_en low outside ISSUE.

Reset
REQ-031 While rst is low, SHALL asynchronously force: FSM = IDLE, rd_en = 0, rd_addr = 0, col_data = 0, col_valid = 0, row_release = 0, busy = 0, top_row = 0, pending = 0, col = 0, k = 0.
REQ-032 A reset asserted mid-line SHALL abandon the line; in-flight BRAM data SHALL be ignored after release.
REQ-033 SHALL wait for line_go after reset deassertion before issuing any read.

Structure
REQ-034 SHALL place the FSM state encoding and the address-width function ($clog2(MEM_DEPTH)) in the shared row-buffer package, also used by the write-address block.
REQ-035 SHALL implement the address computation in one sub-module, rb_slot_addr (inputs top_row, k, col; output addr), reusable by the writer.

Verification
REQ-036 Reset, then one line_go with col_ready = 1 and a BRAM model holding addr value = addr[7:0] -> first col_data = {8'd2, 8'd1, 8'd0} at cycle 5; rd_addr sequence 0, 1, 2, 8, 9, 10, ...
REQ-037 Hold col_ready = 0 for 10 cycles at col 3 -> col_data stable, rd_en = 0 throughout, and resumption at address 32.
REQ-038 Issue 8 line_go pulses (each after busy falls) -> top_row goes 1..7 then wraps to 0; the line with top_row = 6 reads slots 6, 7, 0.
REQ-039 Issue three line_go pulses while busy -> exactly one further line runs, and only 2 row_release pulses in total.
REQ-040 Drop rst at col 100 -> all outputs reach their reset values immediately; the next line_go restarts at address 0.
REQ-041 Random col_ready throttling over 4 lines, checked against a scoreboard -> no lost, duplicated or reordered columns.
